sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter ROWS, default 16, number of SRAM rows; AW = $clog2(ROWS).
REQ-002 Parameter COLS, default 8, SRAM word width in bits.
REQ-003 Parameter TIMEOUT, default 15, maximum read wait in cycles; used only with SRAM_CTRL_TIMEOUT_EN.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  controller accepts a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  target row.
- req_wdata  in  COLS  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  COLS  read data; 0 for writes and errors.
- rsp_err  out  1  error flag for the response.
- busy  out  1  high in any state other than IDLE.
- sram_serial_in  out  1  serial write data bit to the SRAM.
- sram_shift  out  1  SRAM shift-register enable.
- sram_w_en  out  1  SRAM write strobe.
- sram_r_en  out  1  SRAM read strobe.
- sram_addr  out  AW  SRAM row address.
- sram_data_valid  in  1  SRAM read data valid.
- sram_data_out  in  COLS  SRAM read data.

Function
REQ-005 FSM states: IDLE, SHIFT, WRITE, READ, WAIT, RESP; all outputs are registered.
REQ-006 Acceptance: a request is accepted when req_valid and req_ready are both high. On acceptance, the controller latches addr, data and the write flag.
REQ-007 Out-of-range address (req_addr >= ROWS): the FSM goes IDLE->RESP with rsp_err=1 and makes no SRAM strobe.
REQ-008 Write path, IDLE->SHIFT:
- The controller drives sram_shift=1 for exactly COLS consecutive cycles.
- sram_serial_in carries the latched data MSB first, one bit per cycle.
- A bit counter counts 0..COLS-1 and wraps to 0 on exit.
REQ-009 WRITE state: sram_w_en=1 for exactly one cycle with sram_addr = latched addr. The FSM then goes to RESP.
REQ-010 Write latency: accept at cycle T gives first shift at T+1, sram_w_en at T+COLS+1 and rsp_valid at T+COLS+2.
REQ-011 READ state: sram_r_en=1 for exactly one cycle with sram_addr = latched addr. The FSM then goes to WAIT.
REQ-012 sram_data_valid is sampled in both READ and WAIT. The first cycle it is high, the controller captures sram_data_out into rsp_rdata and moves to RESP.
REQ-013 RESP state: rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready is high. In that handshake cycle the FSM returns to IDLE, and rsp_valid is low in the next cycle.
REQ-014 Only one request is outstanding at a time. req_ready=0 from acceptance until the cycle after the response handshake.
REQ-015 When not strobing, sram_shift, sram_w_en, sram_r_en and sram_serial_in are 0.

Reset
REQ-016 When rst is sampled high, the next state is IDLE, counters are 0, and all outputs are 0 except req_ready=1. Any in-flight operation is dropped without a strobe.
REQ-017 Reset has priority over every other event, including a response handshake in the same cycle.

Configuration
REQ-018 With macro SRAM_CTRL_TIMEOUT_EN defined: a wait counter starts with the sram_r_en cycle. If sram_data_valid has not been seen within TIMEOUT+1 cycles, the FSM enters RESP with rsp_err=1 and rsp_rdata=0. A sram_data_valid that arrives later is ignored.
REQ-019 Without SRAM_CTRL_TIMEOUT_EN: no wait counter is built, WAIT persists until sram_data_valid, and rsp_err is asserted only by REQ-007.

Verification (ROWS=16, COLS=8, TIMEOUT=15 unless stated)
REQ-020 Write addr 3, data 0xA5 -> sram_serial_in is 1,0,1,0,0,1,0,1 on 8 shift cycles; one sram_w_en with sram_addr=3; rsp_valid at T+10 with rsp_err=0.
REQ-021 Read addr 3, SRAM model asserts data_valid with 0xA5 two cycles after r_en -> one sram_r_en; rsp_rdata=0xA5 and rsp_err=0.
REQ-022 Hold rsp_ready low for 5 cycles during RESP -> rsp_valid, rsp_rdata and rsp_err stay stable; req_ready=0; no new request is accepted.
REQ-023 With the macro, read with no data_valid -> rsp_err=1 and rsp_rdata=0. Without the macro -> busy stays 1 for 100 cycles.
REQ-024 Assert rst at the 4th shift cycle -> next cycle all outputs are 0, req_ready=1, and no sram_w_en is ever issued.
REQ-025 With ROWS=12, request addr 13 -> rsp_err=1 and no sram_shift, sram_w_en or sram_r_en.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_ctrl_if
// Request/response bus between a requester and the SRAM controller.
//
// Parameters:
//   AW   - address width (row index)
//   COLS - data word width
//
// Signals:
//   req_valid / req_ready  - request handshake
//   req_write              - 1 = write, 0 = read
//   req_addr  [AW-1:0]     - target row
//   req_wdata [COLS-1:0]   - write data
//   rsp_valid / rsp_ready  - response handshake
//   rsp_rdata [COLS-1:0]   - read data (0 for writes and errors)
//   rsp_err                - response error flag
//
// Modports:
//   master - requester side
//   slave  - controller side
// ----------------------------------------------------------------------------
interface sram_ctrl_if #(
    parameter int AW   = 4,
    parameter int COLS = 8
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_ctrl.sv
// ----------------------------------------------------------------------------
// sram_ctrl
// Single-outstanding-request controller for a serially loaded SRAM.
// Writes shift the word into the SRAM MSB first (one bit per cycle) and then
// pulse the write strobe; reads pulse the read strobe and wait for the SRAM
// data-valid flag. Every output is registered.
//
// Optional feature (macro SRAM_CTRL_TIMEOUT_EN): bounded read wait. A read
// that sees no sram_data_valid within TIMEOUT+1 cycles (counting the read
// strobe cycle) completes with rsp_err=1 and rsp_rdata=0.
//
// Parameters:
//   ROWS    - number of SRAM rows (AW = $clog2(ROWS))
//   COLS    - SRAM word width
//   TIMEOUT - read wait limit, used only with SRAM_CTRL_TIMEOUT_EN
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   bus (slave)      - request/response handshake bus
//   busy             - high whenever the FSM is not idle
//   sram_serial_in   - serial write data bit
//   sram_shift       - SRAM shift enable
//   sram_w_en        - SRAM write strobe
//   sram_r_en        - SRAM read strobe
//   sram_addr        - SRAM row address (valid with a strobe, 0 otherwise)
//   sram_data_valid  - SRAM read data valid
//   sram_data_out    - SRAM read data
// ----------------------------------------------------------------------------
module sram_ctrl #(
    parameter  int ROWS    = 16,
    parameter  int COLS    = 8,
    parameter  int TIMEOUT = 15,
    localparam int AW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    sram_ctrl_if.slave      bus,
    output logic            busy,
    output logic            sram_serial_in,
    output logic            sram_shift,
    output logic            sram_w_en,
    output logic            sram_r_en,
    output logic [AW-1:0]   sram_addr,
    input  logic            sram_data_valid,
    input  logic [COLS-1:0] sram_data_out
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [COLS-1:0] r_shreg;
    logic [AW-1:0]   r_addr;

    logic            r_req_ready, w_req_ready_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic            r_rsp_err, w_rsp_err_nxt;
    logic [COLS-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic            r_sram_serial, w_sram_serial_nxt;
    logic            r_sram_shift, w_sram_shift_nxt;
    logic            r_sram_w_en, w_sram_w_en_nxt;
    logic            r_sram_r_en, w_sram_r_en_nxt;
    logic [AW-1:0]   r_sram_addr, w_sram_addr_nxt;

    logic            w_accept;
    logic            w_addr_oor;

`ifdef SRAM_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 2);
    logic [TW-1:0]   r_wait_cnt, w_wait_cnt_nxt;
`endif

    // req_ready is only ever high in IDLE, so this is the acceptance event.
    assign w_accept   = bus.req_valid & r_req_ready;
    assign w_addr_oor = (32'(bus.req_addr) >= ROWS);

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that the registered copies line up with that state.
    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_sram_serial_nxt = 1'b0;
        w_sram_shift_nxt  = 1'b0;
        w_sram_w_en_nxt   = 1'b0;
        w_sram_r_en_nxt   = 1'b0;
        w_sram_addr_nxt   = '0;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_err_nxt     = 1'b0;
        w_rsp_rdata_nxt   = '0;
`ifdef SRAM_CTRL_TIMEOUT_EN
        w_wait_cnt_nxt    = r_wait_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_addr_oor) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else if (bus.req_write) begin
                        // First bit comes straight from the bus; the shift
                        // register is loaded on this same edge.
                        w_state_nxt       = S_SHIFT;
                        w_bit_cnt_nxt     = '0;
                        w_sram_shift_nxt  = 1'b1;
                        w_sram_serial_nxt = bus.req_wdata[COLS-1];
                    end else begin
                        w_state_nxt     = S_READ;
                        w_sram_r_en_nxt = 1'b1;
                        w_sram_addr_nxt = bus.req_addr;
`ifdef SRAM_CTRL_TIMEOUT_EN
                        w_wait_cnt_nxt  = '0;
`endif
                    end
                end
            end

            S_SHIFT: begin
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_nxt     = S_WRITE;
                    w_bit_cnt_nxt   = '0;
                    w_sram_w_en_nxt = 1'b1;
                    w_sram_addr_nxt = r_addr;
                end else begin
                    // r_shreg has already moved past the bit now on the pins.
                    w_bit_cnt_nxt     = r_bit_cnt + 1'b1;
                    w_sram_shift_nxt  = 1'b1;
                    w_sram_serial_nxt = r_shreg[COLS-2];
                end
            end

            S_WRITE: begin
                w_state_nxt     = S_RESP;
                w_rsp_valid_nxt = 1'b1;
            end

            S_READ, S_WAIT: begin
                if (sram_data_valid) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = sram_data_out;
`ifdef SRAM_CTRL_TIMEOUT_EN
                end else if (r_wait_cnt == TW'(TIMEOUT)) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
`else
                end else begin
                    w_state_nxt = S_WAIT;
                end
`endif
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = r_rsp_err;
                    w_rsp_rdata_nxt = r_rsp_rdata;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_req_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_sram_serial <= 1'b0;
            r_sram_shift  <= 1'b0;
            r_sram_w_en   <= 1'b0;
            r_sram_r_en   <= 1'b0;
            r_sram_addr   <= '0;
`ifdef SRAM_CTRL_TIMEOUT_EN
            r_wait_cnt    <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_busy        <= w_busy_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_sram_serial <= w_sram_serial_nxt;
            r_sram_shift  <= w_sram_shift_nxt;
            r_sram_w_en   <= w_sram_w_en_nxt;
            r_sram_r_en   <= w_sram_r_en_nxt;
            r_sram_addr   <= w_sram_addr_nxt;
`ifdef SRAM_CTRL_TIMEOUT_EN
            r_wait_cnt    <= w_wait_cnt_nxt;
`endif
        end
    end

    // Request payload; shifts left once per SHIFT cycle so the next bit to
    // send is always at COLS-2.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_shreg <= bus.req_wdata;
        end else if (r_state == S_SHIFT) begin
            r_shreg <= {r_shreg[COLS-2:0], 1'b0};
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign busy           = r_busy;
    assign sram_serial_in = r_sram_serial;
    assign sram_shift     = r_sram_shift;
    assign sram_w_en      = r_sram_w_en;
    assign sram_r_en      = r_sram_r_en;
    assign sram_addr      = r_sram_addr;

endmodule

// File: tb/tb_sram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_ctrl
// Directed bench for sram_ctrl: one instance with ROWS=16 and one with
// ROWS=12 for the out-of-range address case.
// ----------------------------------------------------------------------------
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_ctrl_if #(.AW(4), .COLS(8)) bus ();
    sram_ctrl_if #(.AW(4), .COLS(8)) bus12 ();

    logic       busy, serial, shift, wen, ren;
    logic [3:0] saddr;
    logic       dvalid;
    logic [7:0] dout;

    logic       busy12, serial12, shift12, wen12, ren12;
    logic [3:0] saddr12;
    logic       dvalid12;
    logic [7:0] dout12;

    assign dvalid12 = 1'b0;
    assign dout12   = 8'h00;

    sram_ctrl #(.ROWS(16), .COLS(8), .TIMEOUT(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .busy            (busy),
        .sram_serial_in  (serial),
        .sram_shift      (shift),
        .sram_w_en       (wen),
        .sram_r_en       (ren),
        .sram_addr       (saddr),
        .sram_data_valid (dvalid),
        .sram_data_out   (dout)
    );

    sram_ctrl #(.ROWS(12), .COLS(8), .TIMEOUT(15)) dut12 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus12),
        .busy            (busy12),
        .sram_serial_in  (serial12),
        .sram_shift      (shift12),
        .sram_w_en       (wen12),
        .sram_r_en       (ren12),
        .sram_addr       (saddr12),
        .sram_data_valid (dvalid12),
        .sram_data_out   (dout12)
    );

    // SRAM model: data_valid two cycles after the read strobe.
    logic       m1 = 1'b0;
    logic       m2 = 1'b0;
    logic       model_en = 1'b1;
    logic [7:0] model_data = 8'h00;
    always @(posedge clk) begin
        m1 <= ren;
        m2 <= m1;
    end
    assign dvalid = m2 & model_en;
    assign dout   = model_data;

    // Strobe monitors.
    int wen_cnt = 0;
    int ren_cnt = 0;
    int strobe12_cnt = 0;
    always @(posedge clk) begin
        if (wen === 1'b1) wen_cnt <= wen_cnt + 1;
        if (ren === 1'b1) ren_cnt <= ren_cnt + 1;
        if ((shift12 | wen12 | ren12) === 1'b1) strobe12_cnt <= strobe12_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] pat;
    int         w0, r0, s0, n;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.rsp_ready = 1'b0;
        bus12.req_valid = 1'b0; bus12.req_write = 1'b0; bus12.req_addr = '0;
        bus12.req_wdata = '0;   bus12.rsp_ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("rst_strobes",   32'({shift, wen, ren, serial}), 32'd0);
        rst = 1'b0;
        tick();

        // Write addr 3, data 0xA5
        pat = 8'hA5;
        w0  = wen_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 4'd3;  bus.req_wdata = pat;
        tick();
        bus.req_valid = 1'b0;
        check("wr_req_ready_low", 32'(bus.req_ready), 32'd0);
        check("wr_busy",          32'(busy),          32'd1);
        for (int i = 0; i < 8; i++) begin
            check("wr_shift", 32'(shift),        32'd1);
            check("wr_bit",   32'(serial),       32'(pat[7-i]));
            check("wr_no_wen", 32'(wen),         32'd0);
            tick();
        end
        check("wr_wen",       32'(wen),           32'd1);
        check("wr_addr",      32'(saddr),         32'd3);
        check("wr_shift_off", 32'(shift),         32'd0);
        check("wr_rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("wr_rsp_err",   32'(bus.rsp_err),   32'd0);
        check("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("wr_wen_once",  32'(wen_cnt - w0),  32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("wr_rsp_done",  32'(bus.rsp_valid), 32'd0);
        check("wr_ready_back", 32'(bus.req_ready), 32'd1);

        // Read addr 3, data valid two cycles after r_en
        model_data = 8'hA5;
        model_en   = 1'b1;
        r0 = ren_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd3;
        tick();
        bus.req_valid = 1'b0;
        check("rd_ren",       32'(ren),           32'd1);
        check("rd_addr",      32'(saddr),         32'd3);
        tick();
        check("rd_ren_off",   32'(ren),           32'd0);
        check("rd_rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick();
        tick();
        check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd_rdata",     32'(bus.rsp_rdata), 32'hA5);
        check("rd_err",       32'(bus.rsp_err),   32'd0);
        check("rd_ren_once",  32'(ren_cnt - r0),  32'd1);

        // Stall the response for 5 cycles with a new request offered
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 4'd7;  bus.req_wdata = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", 32'(bus.rsp_rdata), 32'hA5);
            check("hold_err",   32'(bus.rsp_err),   32'd0);
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("hold_done_valid", 32'(bus.rsp_valid), 32'd0);
        check("hold_no_accept",  32'({busy, shift}), 32'd0);
        check("hold_ready_back", 32'(bus.req_ready), 32'd1);

        // Read with no data_valid
        model_en = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 4'd9;
        tick();
        bus.req_valid = 1'b0;
`ifdef SRAM_CTRL_TIMEOUT_EN
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("to_latency",   32'(n),             32'd16);
        check("to_err",       32'(bus.rsp_err),   32'd1);
        check("to_rdata",     32'(bus.rsp_rdata), 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("to_done", 32'(bus.req_ready), 32'd1);
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b1) n++;
            tick();
        end
        check("wait_busy_100", 32'(n), 32'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wait_rst_busy",  32'(busy),          32'd0);
        check("wait_rst_ready", 32'(bus.req_ready), 32'd1);
`endif
        model_en = 1'b1;

        // Reset during the 4th shift cycle
        pat = 8'h3C;
        w0  = wen_cnt;
        bus.req_valid = 1'b1; bus.req_write = 1'b1;
        bus.req_addr = 4'd5;  bus.req_wdata = pat;
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rw_bit", 32'(serial), 32'(pat[7-i]));
            tick();
        end
        check("rw_shift4", 32'(shift), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_outputs_zero", 32'({busy, shift, wen, ren, serial, saddr}), 32'd0);
        check("rw_rsp_zero",     32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'd0);
        check("rw_req_ready",    32'(bus.req_ready), 32'd1);
        repeat (12) tick();
        check("rw_no_wen", 32'(wen_cnt - w0), 32'd0);

        // ROWS=12: out-of-range address 13
        s0 = strobe12_cnt;
        bus12.req_valid = 1'b1; bus12.req_write = 1'b1;
        bus12.req_addr = 4'd13; bus12.req_wdata = 8'hFF;
        tick();
        bus12.req_valid = 1'b0;
        check("oor_rsp_valid", 32'(bus12.rsp_valid), 32'd1);
        check("oor_err",       32'(bus12.rsp_err),   32'd1);
        check("oor_rdata",     32'(bus12.rsp_rdata), 32'd0);
        check("oor_ready_low", 32'(bus12.req_ready), 32'd0);
        bus12.rsp_ready = 1'b1;
        tick();
        check("oor_done",      32'(bus12.rsp_valid), 32'd0);
        check("oor_ready",     32'(bus12.req_ready), 32'd1);
        check("oor_no_strobe", 32'(strobe12_cnt - s0), 32'd0);

        // ROWS=12: highest legal address 11 proceeds to a write
        bus12.req_valid = 1'b1; bus12.req_write = 1'b1;
        bus12.req_addr = 4'd11; bus12.req_wdata = 8'h81;
        tick();
        bus12.req_valid = 1'b0;
        check("inr_shift", 32'(shift12),       32'd1);
        check("inr_err",   32'(bus12.rsp_err), 32'd0);
        repeat (12) tick();
        check("inr_idle",  32'(busy12),        32'd0);
        bus12.rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
